// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and defaults for the round-robin register write arbiter.
//   state_t    : arbiter FSM state (ST_IDLE, ST_GRANT)
//   N_REQ_DEF  : default number of requesters
//   WIDTH_DEF  : default register / data width
//   idx_width(): width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index width; a single requester still needs one bit to hold index 0.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request mask starting
// at ptr+1 and wrapping, returning the first set requester.
// Ports:
//   req     in   N_REQ  request mask
//   ptr     in   IW     index of the last winner (search starts after it)
//   win     out  N_REQ  one-hot winner (zero when no request)
//   win_idx out  IW     winner index (zero when no request)
//   any     out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IW    = idx_width(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    // Walk offsets 1..N_REQ from ptr; the first requester hit wins.
    always_comb begin
        int unsigned idx;
        logic        hit;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        hit     = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            hit = |(req & (N_REQ'(1) << idx));
            if (!any && hit) begin
                any     = 1'b1;
                win     = N_REQ'(1) << idx;
                win_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin write arbiter that owns a shared WIDTH-bit register. Each
// granted cycle writes the grantee's data into Q at the closing edge; grants
// can run back to back for one write per cycle.
// Ports:
//   clk      in   1            clock, rising edge
//   rst      in   1            synchronous active-high reset
//   req      in   N_REQ        per-requester write request
//   lock     in   N_REQ        (REG_ARB_LOCK_EN only) keep grant for another write
//   wdata    in   N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   gnt      out  N_REQ        registered one-hot grant
//   Q        out  WIDTH        shared register contents
//   q_valid  out  1            Q written since reset
//   src      out  IW           index of the last writer
//   busy     out  1            arbiter in GRANT
// Build option: define REG_ARB_LOCK_EN to add the lock input.
// ---------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
`ifdef REG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         lock,
`endif
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         Q,
    output logic                     q_valid,
    output logic [idx_width(N_REQ)-1:0] src,
    output logic                     busy
);

    localparam int unsigned IW = idx_width(N_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qv_q, qv_d;
    logic [IW-1:0]      src_q, src_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   pick_req_c;
    logic [IW-1:0]      pick_ptr_c;
    logic [N_REQ-1:0]   pick_win_c;
    logic [IW-1:0]      pick_idx_c;
    logic               pick_any_c;
    logic               hold_c;
    logic [WIDTH-1:0]   wsel_c;

    // Grantee keeps the slot while its lock is high.
`ifdef REG_ARB_LOCK_EN
    assign hold_c = |(lock & gnt_q);
`else
    assign hold_c = 1'b0;
`endif

    // Data of the current grantee.
    assign wsel_c = WIDTH'(wdata >> (32'(gidx_q) * WIDTH));

    // In GRANT the current grantee is consumed and the search restarts
    // after it, which is exactly where ptr will land at this edge.
    always_comb begin
        pick_req_c = req;
        pick_ptr_c = ptr_q;
        if (state_q == ST_GRANT) begin
            pick_req_c = req & ~gnt_q;
            pick_ptr_c = gidx_q;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req     (pick_req_c),
        .ptr     (pick_ptr_c),
        .win     (pick_win_c),
        .win_idx (pick_idx_c),
        .any     (pick_any_c)
    );

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            gnt_q   <= '0;
            gidx_q  <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            src_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!hold_c && !pick_any_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = gnt_q;
        gidx_d = gidx_q;
        q_d    = q_q;
        qv_d   = qv_q;
        src_d  = src_q;
        busy_d = (state_d == ST_GRANT);
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_any_c) begin
                    gnt_d  = pick_win_c;
                    gidx_d = pick_idx_c;
                end
            end
            ST_GRANT: begin
                q_d   = wsel_c;
                src_d = gidx_q;
                qv_d  = 1'b1;
                if (!hold_c) begin
                    ptr_d = gidx_q;
                    gnt_d = '0;
                    if (pick_any_c) begin
                        gnt_d  = pick_win_c;
                        gidx_d = pick_idx_c;
                    end
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign Q       = q_q;
    assign q_valid = qv_q;
    assign src     = src_q;
    assign busy    = busy_q;

    // Grant is one-hot or idle, and busy tracks an active grant.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_busy_gnt   : assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));

endmodule
